// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   APB requester. Turns a valid/ready command into one APB SETUP + ACCESS
//   transfer and reports the result on a single-cycle response strobe.
//   A wait-state watchdog aborts an ACCESS phase that sees PREADY low for
//   TIMEOUT consecutive cycles (TIMEOUT = 0 disables the watchdog).
//
// Ports
//   PCLK, PRESET              clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready = state is IDLE)
//   cmd_write/addr/wdata      command payload, captured on acceptance
//   rsp_valid                 one-cycle completion pulse
//   rsp_rdata                 read data (0 for writes and aborted transfers)
//   rsp_err                   transfer aborted by the watchdog
//   PSELx/PENABLE/PWRITE/
//   PADDR/PWDATA              APB request outputs (all registered)
//   PRDATA/PREADY             APB completer inputs
// -----------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSELx,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   // Counter value on the last permitted PREADY-low ACCESS cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_e              state_q, state_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            // A completing PREADY wins over a watchdog expiry in the same cycle.
            if (PREADY) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               state_d     = IDLE;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign PSELx     = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge (TIMEOUT = 4). A vector table drives
//   single transfers with a chosen number of PREADY-low ACCESS cycles; hand
//   sequences cover back-to-back commands against a memory slave and reset
//   in the middle of a transfer. Inputs change and outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       PSELx;
   logic       PENABLE;
   logic       PWRITE;
   logic [3:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;

   logic       use_mem;
   logic [7:0] prdata_drv;
   logic [7:0] mem [16];

   int checks = 0;
   int errors = 0;

   always #5 PCLK = ~PCLK;

   // Simple completer memory for the back-to-back sequence.
   always @(posedge PCLK)
      if (PSELx && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;

   assign PRDATA = use_mem ? mem[PADDR] : prdata_drv;

   apb_master_bridge #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(4), .CNT_W(8)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   typedef struct {
      logic       wr;
      logic [3:0] addr;
      logic [7:0] wdata;
      int         waits;      // PREADY-low ACCESS cycles before PREADY=1
      logic [7:0] prdata;
      logic [7:0] exp_rdata;
      logic       exp_err;
      int         exp_lat;    // edges from accept edge (counted as 1) to rsp_valid
      int         exp_acc;    // ACCESS cycles observed
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge PCLK);
   endtask

   task automatic run_xfer(input int idx, input vec_t v);
      int lat;
      int acc;
      int seen;
      bit done;
      step();
      chk($sformatf("v%0d cmd_ready_idle", idx), 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      PREADY    = 1'b0;
      prdata_drv = v.prdata;
      step();
      lat = 1;
      // SETUP: request on the bus, PREADY pulse here must be ignored.
      chk($sformatf("v%0d setup_psel", idx), 32'(PSELx), 32'd1);
      chk($sformatf("v%0d setup_penable", idx), 32'(PENABLE), 32'd0);
      chk($sformatf("v%0d setup_ready", idx), 32'(cmd_ready), 32'd0);
      chk($sformatf("v%0d setup_paddr", idx), 32'(PADDR), 32'(v.addr));
      chk($sformatf("v%0d setup_pwrite", idx), 32'(PWRITE), 32'(v.wr));
      cmd_valid = 1'b0;
      cmd_addr  = ~v.addr;
      cmd_wdata = ~v.wdata;
      cmd_write = ~v.wr;
      PREADY    = 1'b1;
      acc  = 0;
      seen = 0;
      done = 1'b0;
      while (!done) begin
         step();
         lat++;
         if (rsp_valid) begin
            done = 1'b1;
         end else if (lat > 40) begin
            checks++;
            errors++;
            $display("FAIL v%0d rsp_wait: no rsp_valid within 40 cycles", idx);
            done = 1'b1;
         end else begin
            acc++;
            if (!(PSELx && PENABLE && PADDR == v.addr && PWDATA == v.wdata && PWRITE == v.wr)) begin
               checks++;
               errors++;
               $display("FAIL v%0d access_bus: psel=%0b pen=%0b paddr=%0h pwdata=%0h pwrite=%0b expected 1 1 %0h %0h %0b",
                        idx, PSELx, PENABLE, PADDR, PWDATA, PWRITE, v.addr, v.wdata, v.wr);
            end
            cmd_addr  = 4'($urandom);
            cmd_wdata = 8'($urandom);
            PREADY    = (seen >= v.waits);
            seen++;
         end
      end
      PREADY = 1'b0;
      chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d access_cycles", idx), 32'(acc), 32'(v.exp_acc));
      chk($sformatf("v%0d rsp_rdata", idx), 32'(rsp_rdata), 32'(v.exp_rdata));
      chk($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
      chk($sformatf("v%0d rsp_psel", idx), 32'({PSELx, PENABLE}), 32'd0);
      chk($sformatf("v%0d rsp_ready", idx), 32'(cmd_ready), 32'd1);
      chk($sformatf("v%0d hold_paddr", idx), 32'({PADDR, PWDATA}), 32'({v.addr, v.wdata}));
      step();
      chk($sformatf("v%0d rsp_pulse", idx), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d rsp_hold", idx), 32'({rsp_err, rsp_rdata}), 32'({v.exp_err, v.exp_rdata}));
   endtask

   initial begin
      //        wr    addr   wdata  waits prdata exp_rd  err  lat acc
      tbl[0] = '{1'b1, 4'h3, 8'hA5,  0,  8'hFF, 8'h00, 1'b0, 3, 1};
      tbl[1] = '{1'b0, 4'h3, 8'h00,  2,  8'h5A, 8'h5A, 1'b0, 5, 3};
      tbl[2] = '{1'b0, 4'h7, 8'h00, 99,  8'h33, 8'h00, 1'b1, 6, 4};
      tbl[3] = '{1'b1, 4'hF, 8'h00,  0,  8'h44, 8'h00, 1'b0, 3, 1};
      tbl[4] = '{1'b0, 4'h0, 8'h9C,  3,  8'hC3, 8'hC3, 1'b0, 6, 4};
      tbl[5] = '{1'b0, 4'hA, 8'h00,  0,  8'h81, 8'h81, 1'b0, 3, 1};
      tbl[6] = '{1'b1, 4'h5, 8'hFF,  1,  8'h12, 8'h00, 1'b0, 4, 2};

      PRESET = 1'b1;
      cmd_valid = 1'b1;       // must not be accepted while in reset
      cmd_write = 1'b1;
      cmd_addr  = 4'h9;
      cmd_wdata = 8'h77;
      PREADY    = 1'b1;
      use_mem   = 1'b0;
      prdata_drv = 8'h00;
      repeat (3) step();
      chk("reset_bus", 32'({PSELx, PENABLE, PWRITE, PADDR, PWDATA}), 32'd0);
      chk("reset_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
      cmd_valid = 1'b0;
      PRESET = 1'b0;
      step();
      chk("reset_ready", 32'(cmd_ready), 32'd1);
      chk("reset_idle_psel", 32'(PSELx), 32'd0);

      for (int i = 0; i < 7; i++) run_xfer(i, tbl[i]);

      // Back-to-back: write 1=11 then read 1 with cmd_valid held high.
      use_mem   = 1'b1;
      PREADY    = 1'b1;
      step();
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h1; cmd_wdata = 8'h11;
      step();
      chk("b2b_setup1", 32'({PSELx, PENABLE, PWRITE}), 32'b101);
      cmd_write = 1'b0; cmd_wdata = 8'h00;
      step();
      chk("b2b_access1", 32'({PSELx, PENABLE, PWDATA}), 32'({2'b11, 8'h11}));
      step();
      chk("b2b_rsp1", 32'({rsp_valid, rsp_err, cmd_ready, PSELx, PENABLE}), 32'b10100);
      step();
      cmd_valid = 1'b0;
      chk("b2b_setup2", 32'({rsp_valid, PSELx, PENABLE, PWRITE}), 32'b0100);
      step();
      chk("b2b_access2", 32'({PSELx, PENABLE}), 32'b11);
      step();
      chk("b2b_rsp2", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({2'b10, 8'h11}));
      use_mem = 1'b0;

      // Reset during ACCESS, with cmd_valid high through the reset edge.
      PREADY = 1'b0;
      step();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2;
      step();
      cmd_valid = 1'b0;
      step();
      chk("rst_mid_access", 32'({PSELx, PENABLE}), 32'b11);
      PRESET = 1'b1;
      cmd_valid = 1'b1;
      step();
      chk("rst_mid_bus", 32'({PSELx, PENABLE, PADDR}), 32'd0);
      chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
      PRESET = 1'b0;
      cmd_valid = 1'b0;
      PREADY = 1'b1;
      step();
      chk("rst_mid_after", 32'({rsp_valid, PSELx, cmd_ready}), 32'b001);
      step();
      chk("rst_mid_quiet", 32'({rsp_valid, PSELx}), 32'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator (requester) that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers toward the existing 8-bit-data, 4-bit-address APB peripherals.
- Returns read data or a completion status for each transfer on a one-cycle response strobe.
- Includes a wait-state watchdog so a stuck PREADY cannot hang the requester.
- Sits between a command source (test sequencer or CPU-side logic) and the APB slave bus.

Parameters:
- ADDR_W, 4, PADDR / cmd_addr width
- DATA_W, 8, PWDATA / PRDATA / cmd_wdata / rsp_rdata width
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the watchdog
- CNT_W, 8, width of the wait-state counter; must satisfy TIMEOUT < 2^CNT_W

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  bridge can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  transfer aborted by watchdog (valid with rsp_valid)
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready / transfer complete

Behaviour:
- Clock and reset: one clock PCLK; reset is synchronous and active-high (PRESET sampled on the PCLK rising edge).
- Reset values:
  - State = IDLE.
  - PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the wait counter = 0.
  - cmd_ready = 1 in the first cycle after reset deasserts.
- All outputs are registered. cmd_ready is a decode of state == IDLE.
- States are IDLE, SETUP and ACCESS.
- IDLE:
  - PSELx = 0, PENABLE = 0, cmd_ready = 1.
  - On an edge where cmd_valid = 1, capture cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- SETUP (exactly 1 cycle):
  - PSELx = 1, PENABLE = 0, cmd_ready = 0.
  - Go unconditionally to ACCESS; clear the wait counter.
- ACCESS:
  - PSELx = 1, PENABLE = 1.
  - If PREADY = 1 at the edge: go to IDLE.
    - Next cycle: rsp_valid = 1 and rsp_err = 0.
    - rsp_rdata = PRDATA sampled at that edge for a read, or 0 for a write.
  - Else if TIMEOUT != 0 and the counter == TIMEOUT-1: go to IDLE.
    - Next cycle: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - Else: increment the counter and stay in ACCESS.
- Outputs on return to IDLE: PSELx and PENABLE drop to 0 in the same cycle rsp_valid rises. PWRITE, PADDR and PWDATA hold their last values.
- Latency:
  - Zero-wait transfer is accept edge -> SETUP -> ACCESS -> rsp_valid, i.e. rsp_valid 3 cycles after the accept edge.
  - Each PREADY-low ACCESS cycle adds 1.
  - Minimum command spacing is 3 cycles.
- Back-to-back: in the rsp_valid cycle the state is IDLE and cmd_ready = 1. A command presented there is accepted, so rsp_valid and the next SETUP never overlap.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata and rsp_err hold until the next response.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle; changes on the cmd_* inputs after acceptance are ignored.
- PREADY is ignored outside ACCESS.
- Reset mid-transfer: all outputs reach reset values at the reset edge, the pending response is discarded, and no rsp_valid is produced.
- cmd_valid asserted during reset is not accepted.
- TIMEOUT = 1 aborts after a single PREADY-low ACCESS cycle.

Test Plan:
- Write, zero wait: cmd write addr 4'h3, wdata 8'hA5, PREADY tied 1 -> PSELx=1 for 2 cycles, PENABLE=1 in the second, PADDR=3 and PWDATA=A5 stable throughout; rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read with waits: cmd read addr 4'h3, PREADY low 2 ACCESS cycles then high with PRDATA=8'h5A -> ACCESS lasts 3 cycles; rsp_valid 5 cycles after accept; rsp_rdata=5A.
- Timeout: TIMEOUT=4, PREADY held 0 -> exactly 4 ACCESS cycles, then PSELx=0 and rsp_valid=1 with rsp_err=1, rsp_rdata=0; a following transfer with PREADY=1 completes with rsp_err=0.
- Back-to-back: two commands (write 4'h1=8'h11, then read 4'h1) with cmd_valid held high -> second accepted in the first rsp_valid cycle; SETUP of the second follows with no overlap; read returns 8'h11 from a slave model.
- Reset mid-op: assert PRESET for 1 cycle during ACCESS -> PSELx=PENABLE=0 next cycle, no rsp_valid, cmd_ready=1 after release.
- Stability: change cmd_addr and cmd_wdata every cycle after acceptance -> PADDR and PWDATA unchanged through ACCESS; PREADY pulses outside ACCESS have no effect.
